sat_add_arbiter: RTL and testbench
==================================

# sat_add_arbiter

Shares one 16-bit saturating adder/subtractor between two requesters, e.g. the ALU issue path and the address/PC-offset path, behind valid/ready handshakes. The block arbitrates each cycle and computes the granted operation. It registers the result with its requester ID into a single output stage that honours downstream backpressure. It also keeps a saturating count of overflow events for debug/status.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_a, req0_b  in  16  operands, two's complement
- req0_sub  in  1  1: A−B, 0: A+B
- req0_ready  out  1  requester 0 operation accepted this cycle when valid & ready
- req1_valid, req1_a, req1_b, req1_sub, req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer takes result this cycle when rsp_valid & rsp_ready
- rsp_id  out  1  requester that issued the held result
- rsp_sum  out  16  saturated result
- rsp_ovfl  out  1  signed overflow occurred (result saturated)
- rsp_cout  out  1  raw carry-out of the 16-bit add, pre-saturation
- ovfl_clr  in  1  synchronous clear of ovfl_cnt
- ovfl_cnt  out  8  number of accepted overflowing operations, saturates at 255

## Operation
- Output stage empty/full is the only control state: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready.
  - Grant goes to at most one requester.
  - reqN_ready = grantN & can_accept & ~rst.
  - A ready is never raised toward an invalid requester.
- Accept: the granted operation is computed combinationally and loaded with {id, sum, ovfl, cout} at the clock edge; rsp_valid=1.
- Drain without accept: rsp_valid & rsp_ready with no valid requester → rsp_valid=0 next cycle.
  - rsp_sum, rsp_id, rsp_ovfl and rsp_cout hold their last values.
- Held result is stable while rsp_valid & ~rsp_ready.
- Arithmetic:
  - B' = sub ? ~B : B; raw = A + B' + sub (17 bits); cout = raw[16].
  - Positive overflow: A[15]=B'[15]=0 and raw[15]=1 → sum 16'h7FFF, ovfl=1.
  - Negative overflow: A[15]=B'[15]=1 and raw[15]=0 → sum 16'h8000, ovfl=1.
  - Otherwise sum = raw[15:0], ovfl=0.
- ovfl_cnt:
  - Increments by 1 on each accept with ovfl=1; holds at 255.
  - ovfl_clr alone → 0.
  - ovfl_clr with an overflowing accept in the same cycle → 1. The clear applies first, then the increment.
- Arbitration (see Configuration): only one requester valid → it is granted.

## Timing
- Latency: operation accepted at edge N → result visible on rsp_* right after edge N (one cycle from request to response).
- Throughput: one operation per cycle when rsp_ready is held 1.
- Back-to-back accept and drain in the same cycle is allowed; the new result replaces the drained one.
- Requester must hold valid and operands stable until ready; the arbiter may move the grant only when no accept occurs.
- Reset values:
  - rsp_valid 0, rsp_id 0, rsp_sum 16'h0000, rsp_ovfl 0, rsp_cout 0, ovfl_cnt 0.
  - Internal last_grant = 1.
  - req0_ready and req1_ready are 0 while rst=1.
- Reset mid-operation discards the held result immediately (asynchronous); no response is emitted for it.

## Configuration
- SAT_ADD_ARB_RR_EN defined: round-robin arbitration.
  - With both valid, grant the requester ≠ last_grant.
  - last_grant updates only on accept.
  - First contended grant after reset goes to req0.
- Not defined: fixed priority; req0 always wins when both are valid; last_grant unused.

## Test plan
- req0: 7FFF + 0001, add → next cycle rsp_valid=1, id=0, sum=7FFF, ovfl=1, cout=0; ovfl_cnt=1.
- req1: 8000 − 0001, sub → sum=8000, ovfl=1, cout=1, id=1; then 0005 − 0003 → sum=0002, ovfl=0, cout=1; ovfl_cnt unchanged by second op.
- Both valid continuously, rsp_ready=1:
  - With SAT_ADD_ARB_RR_EN, rsp_id sequence is 0,1,0,1.
  - Without it, rsp_id is 0,0,0,0 and req1_ready never asserts.
- rsp_ready=0 with rsp_valid=1 for 3 cycles → both readies 0, rsp_* stable. Raise rsp_ready → a pending request is accepted that same cycle and the new result appears the next cycle.
- 256 overflowing ops → ovfl_cnt=255. Then ovfl_clr together with an overflowing accept → ovfl_cnt=1.
- Assert rst while rsp_valid=1 and both requests pending:
  - rsp_valid drops immediately; ovfl_cnt=0; readies 0 during reset.
  - After release, with RR enabled, first grant goes to req0.

Source files
------------

// File: rtl/sat_add_arbiter.sv
// Two-requester arbiter in front of one 16-bit saturating add/sub with a single registered output slot.
// Define SAT_ADD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sat_add_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_sub,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_sub,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_ovfl,
    output logic        rsp_cout,
    input  logic        ovfl_clr,
    output logic [7:0]  ovfl_cnt
);

    // Returns {cout, ovfl, sum}; cout is the raw carry before saturation.
    function automatic logic [17:0] sat_addsub(input logic [15:0] a, input logic [15:0] b,
                                               input logic sub);
        logic [15:0] b_eff;
        logic [16:0] raw;
        logic [15:0] sum;
        logic        ovfl;
        b_eff = sub ? ~b : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {16'b0, sub};
        if (~a[15] & ~b_eff[15] & raw[15]) begin
            sum  = 16'h7FFF;
            ovfl = 1'b1;
        end else if (a[15] & b_eff[15] & ~raw[15]) begin
            sum  = 16'h8000;
            ovfl = 1'b1;
        end else begin
            sum  = raw[15:0];
            ovfl = 1'b0;
        end
        return {raw[16], ovfl, sum};
    endfunction

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q,    rsp_id_d;
    logic [15:0] rsp_sum_q,   rsp_sum_d;
    logic        rsp_ovfl_q,  rsp_ovfl_d;
    logic        rsp_cout_q,  rsp_cout_d;
    logic [7:0]  ovfl_cnt_q,  ovfl_cnt_d;
`ifdef SAT_ADD_ARB_RR_EN
    logic        last_grant_q, last_grant_d;
`endif

    logic        grant0_s, grant1_s;
    logic        can_accept_s;
    logic        accept_s;
    logic [15:0] op_a_s, op_b_s;
    logic        op_sub_s;
    logic [17:0] res_s;
    logic [7:0]  cnt_base_s;

    // Grant selection: a lone valid requester always wins; contention resolved by policy.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid & req1_valid) begin
`ifdef SAT_ADD_ARB_RR_EN
            grant0_s = last_grant_q;
            grant1_s = ~last_grant_q;
`else
            grant0_s = 1'b1;
            grant1_s = 1'b0;
`endif
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    assign can_accept_s = ~rsp_valid_q | rsp_ready;
    assign req0_ready   = grant0_s & can_accept_s & ~rst;
    assign req1_ready   = grant1_s & can_accept_s & ~rst;
    assign accept_s     = req0_ready | req1_ready;

    // Operand mux toward the shared adder, then the saturating compute.
    always_comb begin
        op_a_s   = req0_a;
        op_b_s   = req0_b;
        op_sub_s = req0_sub;
        if (req1_ready) begin
            op_a_s   = req1_a;
            op_b_s   = req1_b;
            op_sub_s = req1_sub;
        end else begin
            op_a_s   = req0_a;
            op_b_s   = req0_b;
            op_sub_s = req0_sub;
        end
        res_s = sat_addsub(op_a_s, op_b_s, op_sub_s);
    end

    // Output slot next state: load on accept, empty on a bare drain, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovfl_d  = rsp_ovfl_q;
        rsp_cout_d  = rsp_cout_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = req1_ready;
            rsp_sum_d   = res_s[15:0];
            rsp_ovfl_d  = res_s[16];
            rsp_cout_d  = res_s[17];
        end else if (rsp_valid_q & rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Overflow counter: clear takes effect before the same-cycle increment.
    always_comb begin
        cnt_base_s = ovfl_cnt_q;
        ovfl_cnt_d = ovfl_cnt_q;
        if (ovfl_clr) begin
            cnt_base_s = 8'd0;
        end else begin
            cnt_base_s = ovfl_cnt_q;
        end
        if (accept_s & res_s[16] & (cnt_base_s != 8'hFF)) begin
            ovfl_cnt_d = cnt_base_s + 8'd1;
        end else begin
            ovfl_cnt_d = cnt_base_s;
        end
    end

`ifdef SAT_ADD_ARB_RR_EN
    // Remember who won the last accepted operation.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_s) begin
            last_grant_d = req1_ready;
        end else begin
            last_grant_d = last_grant_q;
        end
    end
`endif

    // State registers; reset discards any held result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= 16'h0000;
            rsp_ovfl_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            ovfl_cnt_q   <= 8'd0;
`ifdef SAT_ADD_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_ovfl_q   <= rsp_ovfl_d;
            rsp_cout_q   <= rsp_cout_d;
            ovfl_cnt_q   <= ovfl_cnt_d;
`ifdef SAT_ADD_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovfl  = rsp_ovfl_q;
    assign rsp_cout  = rsp_cout_q;
    assign ovfl_cnt  = ovfl_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed self-checking bench for sat_add_arbiter with a result scoreboard.
module tb_sat_add_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_sub, req0_ready;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_sub, req1_ready;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovfl, rsp_cout;
    logic [15:0] rsp_sum;
    logic        ovfl_clr;
    logic [7:0]  ovfl_cnt;

    sat_add_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_ovfl(rsp_ovfl), .rsp_cout(rsp_cout),
        .ovfl_clr(ovfl_clr), .ovfl_cnt(ovfl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [18:0] sb_q[$];
    logic        m_valid, m_last;
    logic [7:0]  m_cnt;
    logic [18:0] m_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {id, sum, ovfl, cout}, from signed integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic id);
        int          sa, sbv, r;
        logic [15:0] nb, sum;
        logic [31:0] u;
        logic        ov;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        r   = sub ? sa - sbv : sa + sbv;
        nb  = sub ? ~b : b;
        u   = {16'd0, a} + {16'd0, nb} + {31'd0, sub};
        if (r > 32767) begin
            sum = 16'h7FFF; ov = 1'b1;
        end else if (r < -32768) begin
            sum = 16'h8000; ov = 1'b1;
        end else begin
            sum = r[15:0];  ov = 1'b0;
        end
        return {id, sum, ov, u[16]};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b1;
        m_cnt   = 8'd0;
        m_hold  = 19'd0;
        sb_q.delete();
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    endtask

    task automatic set1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    endtask

    // One clock: check readies and held result before the edge, state after it.
    task automatic cyc();
        logic        can, g0, g1, e0, e1;
        logic [18:0] exp, obs;
        #1;
        can = ~m_valid | rsp_ready;
        if (req0_valid & req1_valid) begin
`ifdef SAT_ADD_ARB_RR_EN
            g0 = m_last;
`else
            g0 = 1'b1;
`endif
            g1 = ~g0;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
        e0 = g0 & can;
        e1 = g1 & can;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("rsp_valid_pre", 32'(rsp_valid), 32'(m_valid));
        obs = {rsp_id, rsp_sum, rsp_ovfl, rsp_cout};
        if (m_valid) begin
            chk("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                chk("rsp_result", 32'(obs), 32'(sb_q[0]));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
        exp = e1 ? model(req1_a, req1_b, req1_sub, 1'b1) : model(req0_a, req0_b, req0_sub, 1'b0);
        @(posedge clk);
        if (m_valid & rsp_ready) m_valid = 1'b0;
        if (ovfl_clr) m_cnt = 8'd0;
        if (e0 | e1) begin
            sb_q.push_back(exp);
            m_hold  = exp;
            m_valid = 1'b1;
            m_last  = e1;
            if (exp[1] && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end
        @(negedge clk);
        chk("rsp_valid_post", 32'(rsp_valid), 32'(m_valid));
        chk("ovfl_cnt", 32'(ovfl_cnt), 32'(m_cnt));
        chk("rsp_hold", 32'({rsp_id, rsp_sum, rsp_ovfl, rsp_cout}), 32'(m_hold));
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        ovfl_clr  = 1'b0;
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        model_reset();

        // Reset state, with requests pending
        #2;
        set0(1'b1, 16'h1111, 16'h2222, 1'b0);
        set1(1'b1, 16'h3333, 16'h4444, 1'b1);
        rsp_ready = 1'b1;
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fields", 32'({rsp_id, rsp_sum, rsp_ovfl, rsp_cout}), 32'd0);
        chk("rst_ovfl_cnt", 32'(ovfl_cnt), 32'd0);
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Positive overflow from requester 0
        set0(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        cyc();
        chk("t1_sum", 32'(rsp_sum), 32'h7FFF);
        chk("t1_ovfl_cnt", 32'(ovfl_cnt), 32'd1);
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();

        // Requester 1 subtracts: negative overflow, then a plain difference
        set1(1'b1, 16'h8000, 16'h0001, 1'b1);
        cyc();
        chk("t2_sum", 32'(rsp_sum), 32'h8000);
        set1(1'b1, 16'h0005, 16'h0003, 1'b1);
        cyc();
        chk("t2b_sum", 32'(rsp_sum), 32'h0002);
        chk("t2b_ovfl_cnt", 32'(ovfl_cnt), 32'd2);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();

        // Contention with full throughput
        set0(1'b1, 16'h1234, 16'h1111, 1'b0);
        set1(1'b1, 16'hF000, 16'h0100, 1'b1);
        for (int i = 0; i < 4; i++) cyc();
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();

        // Backpressure: hold 3 cycles, then accept and drain in the same cycle
        set0(1'b1, 16'h4000, 16'h4000, 1'b0);
        set1(1'b1, 16'h0001, 16'h8000, 1'b1);
        cyc();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        rsp_ready = 1'b1;
        cyc();
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();

        // Counter saturation, clear with concurrent overflow, clear alone
        set0(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        for (int i = 0; i < 256; i++) cyc();
        chk("sat_ovfl_cnt", 32'(ovfl_cnt), 32'd255);
        ovfl_clr = 1'b1;
        cyc();
        chk("clr_inc_ovfl_cnt", 32'(ovfl_cnt), 32'd1);
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();
        chk("clr_ovfl_cnt", 32'(ovfl_cnt), 32'd0);
        ovfl_clr = 1'b0;
        set0(1'b1, 16'h8000, 16'hFFFF, 1'b0);
        cyc();

        // Reset while a result is held and both requesters wait
        rsp_ready = 1'b0;
        set0(1'b1, 16'h0001, 16'h0002, 1'b0);
        set1(1'b1, 16'h0010, 16'h0003, 1'b1);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ovfl_cnt", 32'(ovfl_cnt), 32'd0);
        chk("mid_rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("mid_rst_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        chk("post_rst_first_id", 32'(rsp_id), 32'd0);
        set0(1'b0, 16'h0000, 16'h0000, 1'b0);
        set1(1'b0, 16'h0000, 16'h0000, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
